// File: rtl/sync_fifo_param.sv
// sync_fifo_param -- parametrised single-clock FIFO.
//
// Stores DEPTH words of DATA_W bits. It has programmable almost-full and
// almost-empty thresholds, an occupancy count and one-cycle
// overflow/underflow pulses. All flags decode from the registered occupancy
// count, so no combinational path runs from wr_en/rd_en to any flag.
//
// Build option:
//   FIFO_FWFT_EN  defined   -> first-word-fall-through. dout shows the head
//                              word whenever the FIFO is not empty, and
//                              valid = !empty.
//                 undefined -> standard registered read. dout is loaded on an
//                              accepted read, and valid pulses for one cycle.
//
// Parameters:
//   DATA_W     data width in bits (>= 1)
//   DEPTH      number of entries; power of two, >= 4
//   AF_THRESH  almost_full  when data_count >= AF_THRESH (1..DEPTH)
//   AE_THRESH  almost_empty when data_count <= AE_THRESH (0..DEPTH-1)
//
// Ports:
//   clk          sole clock, rising edge
//   srst         asynchronous active-high reset
//   din, wr_en   write data / write request (ignored while full)
//   rd_en        read request / pop (ignored while empty)
//   dout, valid  read data and its qualifier
//   full, empty, almost_full, almost_empty   occupancy flags
//   data_count   entries stored, 0..DEPTH
//   overflow     one-cycle pulse for a write rejected because the FIFO was full
//   underflow    one-cycle pulse for a read rejected because the FIFO was empty
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic [DATA_W-1:0]        din,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        dout,
  output logic                     valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   data_count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_ok;
  logic              rd_ok;

  // Flags come from the registered count only.
  always_comb begin
    full         = (data_count == DEPTH_C);
    empty        = (data_count == '0);
    almost_full  = (data_count >= AF_C);
    almost_empty = (data_count <= AE_C);
  end

  // When the FIFO is full, a simultaneous read is still accepted and the write
  // is rejected. When it is empty, the write is accepted and the read is
  // rejected. Both cases follow directly from gating each side with its own
  // pre-edge flag.
  always_comb begin
    wr_ok = wr_en && !full;
    rd_ok = rd_en && !empty;
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_count <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   data_count <= data_count + 1'b1;
        2'b01:   data_count <= data_count - 1'b1;
        default: data_count <= data_count;
      endcase
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

  // Storage has no reset; stale contents become unreachable once the pointers
  // and count clear.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

`ifdef FIFO_FWFT_EN
  // dout is forced to zero while empty so that reset and the empty state show
  // a defined value instead of a stale memory word.
  always_comb begin
    dout  = empty ? '0 : mem[rd_ptr];
    valid = !empty;
  end
`else
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      dout  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= rd_ok;
      if (rd_ok) dout <= mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

  logic       clk;
  logic       srst;
  logic [7:0] din;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] dout;
  logic       valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] data_count;
  logic       overflow;
  logic       underflow;

  int unsigned vectors;
  int unsigned miscompares;

  logic [7:0] rd;
  logic [3:0] fl_got;
  logic [3:0] fl_exp;
  logic [7:0] q[$];

  sync_fifo_param #(
    .DATA_W   (8),
    .DEPTH    (16),
    .AF_THRESH(14),
    .AE_THRESH(2)
  ) dut (
    .clk         (clk),
    .srst        (srst),
    .din         (din),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .dout        (dout),
    .valid       (valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .data_count  (data_count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle with the given requests. rdata is the word that an
  // accepted read in this cycle delivers. In FWFT mode that word is on dout
  // before the edge; in standard mode it is on dout after the edge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r,
                     output logic [7:0] rdata);
    wr_en = w;
    din   = d;
    rd_en = r;
`ifdef FIFO_FWFT_EN
    rdata = dout;
`endif
    @(posedge clk);
    #1;
`ifndef FIFO_FWFT_EN
    rdata = dout;
`endif
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    srst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    fl_got = {full, empty, almost_full, almost_empty};
    if (fl_got !== 4'b0101) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 0101", fl_got);
    end
    vectors++;
    if ({data_count, dout, valid, overflow, underflow} !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_state: count=%0d dout=%h valid=%b ovf=%b udf=%b want all 0",
               data_count, dout, valid, overflow, underflow);
    end
    srst = 1'b0;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0, rd);
      fl_got = {full, empty, almost_full, almost_empty};
      fl_exp = {(i + 1 == 16), 1'b0, (i + 1 >= 14), (i + 1 <= 2)};
      vectors++;
      if (fl_got !== fl_exp || data_count !== 5'(i + 1)) begin
        miscompares++;
        $display("FAIL fill[%0d]: flags=%b count=%0d want flags=%b count=%0d",
                 i, fl_got, data_count, fl_exp, i + 1);
      end
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1, rd);
      vectors++;
      if (rd !== 8'(i) || data_count !== 5'(15 - i)) begin
        miscompares++;
        $display("FAIL drain[%0d]: data=%h count=%0d want data=%h count=%0d",
                 i, rd, data_count, 8'(i), 15 - i);
      end
`ifndef FIFO_FWFT_EN
      vectors++;
      if (valid !== 1'b1) begin
        miscompares++;
        $display("FAIL drain_valid[%0d]: got %b want 1", i, valid);
      end
`endif
    end
    cyc(1'b0, 8'h00, 1'b0, rd);
    vectors++;
    if (empty !== 1'b1 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_end: empty=%b valid=%b want empty=1 valid=0", empty, valid);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, rd);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 8'hFF, 1'b0, rd);
      vectors++;
      if (overflow !== 1'b1 || data_count !== 5'd16) begin
        miscompares++;
        $display("FAIL ovf[%0d]: overflow=%b count=%0d want overflow=1 count=16",
                 i, overflow, data_count);
      end
    end
    cyc(1'b0, 8'h00, 1'b0, rd);
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clear: got %b want 0", overflow);
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1, rd);
      vectors++;
      if (rd !== 8'(8'h40 + i)) begin
        miscompares++;
        $display("FAIL ovf_drain[%0d]: got %h want %h", i, rd, 8'(8'h40 + i));
      end
    end
  endtask

  task automatic test_underflow();
    cyc(1'b0, 8'h00, 1'b1, rd);
    vectors++;
    if (underflow !== 1'b1 || valid !== 1'b0 || data_count !== 5'd0) begin
      miscompares++;
      $display("FAIL udf: underflow=%b valid=%b count=%0d want 1 0 0",
               underflow, valid, data_count);
    end
    cyc(1'b0, 8'h00, 1'b0, rd);
    vectors++;
    if (underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL udf_clear: got %b want 0", underflow);
    end
    cyc(1'b1, 8'hA5, 1'b1, rd);
    vectors++;
    if (underflow !== 1'b1 || data_count !== 5'd1 || empty !== 1'b0) begin
      miscompares++;
      $display("FAIL udf_rw: underflow=%b count=%0d empty=%b want 1 1 0",
               underflow, data_count, empty);
    end
    cyc(1'b0, 8'h00, 1'b1, rd);
    vectors++;
    if (rd !== 8'hA5 || data_count !== 5'd0) begin
      miscompares++;
      $display("FAIL udf_rw_read: data=%h count=%0d want a5 0", rd, data_count);
    end
  endtask

  task automatic test_full_rdwr();
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, rd);
    cyc(1'b1, 8'h3C, 1'b1, rd);
    vectors++;
    if (rd !== 8'h80 || data_count !== 5'd15 || overflow !== 1'b1 || full !== 1'b0) begin
      miscompares++;
      $display("FAIL full_rw: data=%h count=%0d ovf=%b full=%b want 80 15 1 0",
               rd, data_count, overflow, full);
    end
    for (int i = 0; i < 15; i++) begin
      cyc(1'b0, 8'h00, 1'b1, rd);
      vectors++;
      if (rd !== 8'(8'h81 + i)) begin
        miscompares++;
        $display("FAIL full_rw_drain[%0d]: got %h want %h", i, rd, 8'(8'h81 + i));
      end
    end
    vectors++;
    if (empty !== 1'b1) begin
      miscompares++;
      $display("FAIL full_rw_empty: got %b want 1", empty);
    end
  endtask

  // Forty writes with occupancy held between 3 and 5, then a drain. The write
  // and read pointers wrap more than twice.
  task automatic test_wrap();
    logic       w;
    logic       r;
    logic [7:0] d;
    logic [7:0] exp;
    int unsigned wcnt;
    int unsigned k;
    wcnt = 0;
    q.delete();
    for (int n = 0; n < 64 || q.size() > 0; n++) begin
      k = (n >= 3) ? 32'((n - 3) % 5) : 0;
      if (n < 3 || n == 63) begin w = 1'b1; r = 1'b0; end
      else if (n > 63)      begin w = 1'b0; r = 1'b1; end
      else begin
        w = (k == 0 || k == 1 || k == 4);
        r = (k == 2 || k == 3 || k == 4);
      end
      d = 8'(wcnt * 13 + 5);
      cyc(w, d, r, rd);
      if (r) begin
        exp = q.pop_front();
        vectors++;
        if (rd !== exp) begin
          miscompares++;
          $display("FAIL wrap_data[%0d]: got %h want %h", n, rd, exp);
        end
      end
      if (w) begin
        q.push_back(d);
        wcnt++;
      end
      vectors++;
      if (data_count !== 5'(q.size()) || almost_empty !== (q.size() <= 2)) begin
        miscompares++;
        $display("FAIL wrap_count[%0d]: count=%0d ae=%b want count=%0d ae=%b",
                 n, data_count, almost_empty, q.size(), (q.size() <= 2));
      end
    end
    vectors++;
    if (wcnt != 40 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_end: writes=%0d empty=%b want 40 1", wcnt, empty);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h21 + i), 1'b0, rd);
    cyc(1'b0, 8'h00, 1'b1, rd);
    vectors++;
    if (rd !== 8'h21 || data_count !== 5'd7) begin
      miscompares++;
      $display("FAIL rstmid_pre: data=%h count=%0d want 21 7", rd, data_count);
    end
    wr_en = 1'b1;
    din   = 8'h99;
    #2;
    srst = 1'b1;
    #1;
    vectors++;
    if (empty !== 1'b1 || data_count !== 5'd0 || dout !== 8'h00 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_async: empty=%b count=%0d dout=%h valid=%b want 1 0 00 0",
               empty, data_count, dout, valid);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    srst  = 1'b0;
    vectors++;
    if (data_count !== 5'd0) begin
      miscompares++;
      $display("FAIL rstmid_hold: count=%0d want 0", data_count);
    end
    cyc(1'b1, 8'h11, 1'b0, rd);
    cyc(1'b0, 8'h00, 1'b1, rd);
    vectors++;
    if (rd !== 8'h11 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_post: data=%h empty=%b want 11 1", rd, empty);
    end
  endtask

`ifdef FIFO_FWFT_EN
  task automatic test_fwft();
    cyc(1'b1, 8'h5A, 1'b0, rd);
    vectors++;
    if (dout !== 8'h5A || empty !== 1'b0 || valid !== 1'b1) begin
      miscompares++;
      $display("FAIL fwft_show: dout=%h empty=%b valid=%b want 5a 0 1", dout, empty, valid);
    end
    cyc(1'b0, 8'h00, 1'b1, rd);
    vectors++;
    if (empty !== 1'b1 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fwft_pop: empty=%b valid=%b want 1 0", empty, valid);
    end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_full_rdwr();
    test_wrap();
    test_reset_mid();
`ifdef FIFO_FWFT_EN
    test_fwft();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
